// File: rtl/bridge_arbiter.sv
// bridge_arbiter
//   Two-requester transfer scheduler in front of the DRAM/SD bridge. It grants
//   one copy request at a time, issues it to the bridge as a single-cycle
//   strobe, gathers the 8-byte result burst (MSB byte first) into a 64-bit
//   word, and reports it with the requester ID and the issue-to-last-byte
//   latency.
//
// Parameters
//   ISSUE_GAP      idle cycles after each completion before re-arbitrating (0..15)
//
// Configuration macro
//   BRIDGE_ARB_FIXED_PRIO_EN  defined: requester 0 wins every tie.
//                             undefined (default): round-robin on ties.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid/ready            request handshake for requester N (0/1)
//   reqN_dir/addr_dram/addr_sd  request fields for requester N
//   br_in_valid                 one-cycle request strobe to the bridge
//   br_direction/addr_*         request fields, zero unless br_in_valid
//   br_out_valid/out_data       result bytes returned by the bridge
//   done_valid                  one-cycle completion strobe
//   done_id/dir/data/lat        completion fields, held until the next completion
//   busy                        high whenever the scheduler is not idle
module bridge_arbiter #(
  parameter int ISSUE_GAP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_dir,
  input  logic [12:0] req0_addr_dram,
  input  logic [15:0] req0_addr_sd,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_dir,
  input  logic [12:0] req1_addr_dram,
  input  logic [15:0] req1_addr_sd,
  output logic        br_in_valid,
  output logic        br_direction,
  output logic [12:0] br_addr_dram,
  output logic [15:0] br_addr_sd,
  input  logic        br_out_valid,
  input  logic [7:0]  br_out_data,
  output logic        done_valid,
  output logic        done_id,
  output logic        done_dir,
  output logic [63:0] done_data,
  output logic [15:0] done_lat,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    COLLECT,
    DONE,
    GAP
  } state_t;

  // Final gap count before returning to IDLE; unused when ISSUE_GAP is 0.
  localparam logic [3:0] GapLast = 4'(ISSUE_GAP - 1);

  state_t      state_q, state_d;
  logic        lastGrant_q, lastGrant_d;
  logic        grantId_q, grantId_d;
  logic        dir_q, dir_d;
  logic [12:0] addrDram_q, addrDram_d;
  logic [15:0] addrSd_q, addrSd_d;
  logic [15:0] lat_q, lat_d;
  logic [2:0]  byteCnt_q, byteCnt_d;
  logic [3:0]  gapCnt_q, gapCnt_d;
  logic [55:0] colData_q, colData_d;
  logic        doneValid_q, doneValid_d;
  logic        doneId_q, doneId_d;
  logic        doneDir_q, doneDir_d;
  logic [63:0] doneData_q, doneData_d;
  logic [15:0] doneLat_q, doneLat_d;

  logic        pick1;
  logic [15:0] latInc;

  // Latency counter sticks at all-ones instead of wrapping.
  assign latInc = (lat_q == 16'hFFFF) ? lat_q : lat_q + 16'd1;

  // Winner selection, meaningful only when at least one requester is valid.
  // Round-robin gives the tie to whoever did not win last time.
  always_comb begin
    if (req0_valid && req1_valid) begin
`ifdef BRIDGE_ARB_FIXED_PRIO_EN
      pick1 = 1'b0;
`else
      pick1 = ~lastGrant_q;
`endif
    end else begin
      pick1 = req1_valid;
    end
  end

  // Next-state and output decode. Bytes are shifted in so that the first byte
  // ends up in the top of the word once all eight have arrived; the completion
  // registers are loaded in the same cycle the last byte is captured.
  always_comb begin
    state_d      = state_q;
    lastGrant_d  = lastGrant_q;
    grantId_d    = grantId_q;
    dir_d        = dir_q;
    addrDram_d   = addrDram_q;
    addrSd_d     = addrSd_q;
    lat_d        = lat_q;
    byteCnt_d    = byteCnt_q;
    gapCnt_d     = gapCnt_q;
    colData_d    = colData_q;
    doneValid_d  = 1'b0;
    doneId_d     = doneId_q;
    doneDir_d    = doneDir_q;
    doneData_d   = doneData_q;
    doneLat_d    = doneLat_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    br_in_valid  = 1'b0;
    br_direction = 1'b0;
    br_addr_dram = 13'd0;
    br_addr_sd   = 16'd0;

    case (state_q)
      IDLE: begin
        if (req0_valid || req1_valid) begin
          if (pick1) begin
            req1_ready = 1'b1;
            dir_d      = req1_dir;
            addrDram_d = req1_addr_dram;
            addrSd_d   = req1_addr_sd;
          end else begin
            req0_ready = 1'b1;
            dir_d      = req0_dir;
            addrDram_d = req0_addr_dram;
            addrSd_d   = req0_addr_sd;
          end
          grantId_d   = pick1;
          lastGrant_d = pick1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        br_in_valid  = 1'b1;
        br_direction = dir_q;
        br_addr_dram = addrDram_q;
        br_addr_sd   = addrSd_q;
        lat_d        = 16'd0;
        state_d      = WAIT;
      end
      WAIT: begin
        lat_d = latInc;
        if (br_out_valid) begin
          colData_d = {48'd0, br_out_data};
          byteCnt_d = 3'd1;
          state_d   = COLLECT;
        end
      end
      COLLECT: begin
        lat_d = latInc;
        if (br_out_valid) begin
          colData_d = {colData_q[47:0], br_out_data};
          byteCnt_d = byteCnt_q + 3'd1;
          if (byteCnt_q == 3'd7) begin
            doneValid_d = 1'b1;
            doneId_d    = grantId_q;
            doneDir_d   = dir_q;
            doneData_d  = {colData_q, br_out_data};
            doneLat_d   = latInc;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        gapCnt_d = 4'd0;
        state_d  = (ISSUE_GAP == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gapCnt_q == GapLast) begin
          state_d = IDLE;
        end else begin
          gapCnt_d = gapCnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; a reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lastGrant_q <= 1'b1;
      grantId_q   <= 1'b0;
      dir_q       <= 1'b0;
      addrDram_q  <= 13'd0;
      addrSd_q    <= 16'd0;
      lat_q       <= 16'd0;
      byteCnt_q   <= 3'd0;
      gapCnt_q    <= 4'd0;
      colData_q   <= 56'd0;
      doneValid_q <= 1'b0;
      doneId_q    <= 1'b0;
      doneDir_q   <= 1'b0;
      doneData_q  <= 64'd0;
      doneLat_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      lastGrant_q <= lastGrant_d;
      grantId_q   <= grantId_d;
      dir_q       <= dir_d;
      addrDram_q  <= addrDram_d;
      addrSd_q    <= addrSd_d;
      lat_q       <= lat_d;
      byteCnt_q   <= byteCnt_d;
      gapCnt_q    <= gapCnt_d;
      colData_q   <= colData_d;
      doneValid_q <= doneValid_d;
      doneId_q    <= doneId_d;
      doneDir_q   <= doneDir_d;
      doneData_q  <= doneData_d;
      doneLat_q   <= doneLat_d;
    end
  end

  assign done_valid = doneValid_q;
  assign done_id    = doneId_q;
  assign done_dir   = doneDir_q;
  assign done_data  = doneData_q;
  assign done_lat   = doneLat_q;
  assign busy       = (state_q != IDLE);

endmodule
